// File: rtl/pwm_duty_ramp.sv
// Duty-cycle ramp generator for a 4096-cycle PWM stage: accepts target duty values
// and walks dc toward them by at most `step` per PWM period, updating only at period boundaries.
module pwm_duty_ramp #(
    parameter logic [11:0] DC_INIT = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] tgt_data,
    input  logic        tgt_valid,
    output logic        tgt_ready,
    input  logic [11:0] step,
    output logic [11:0] dc,
    output logic        period_tick,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [11:0] dc_q, dc_d;
    logic [11:0] tgt_q, tgt_d;
    logic [11:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        boundary;
    logic        xfer;
    logic [11:0] eff_tgt;
    logic [11:0] eff_tgt_d;

    // One ramp move: 13-bit magnitude compare so the result lands exactly on the
    // target instead of overshooting, wrapping past 12'hFFF or dropping below zero.
    function automatic logic [11:0] ramp_next(input logic [11:0] cur,
                                              input logic [11:0] target,
                                              input logic [11:0] stp);
        logic [12:0] diff;
        logic [11:0] nxt;
        if (target >= cur) diff = {1'b0, target} - {1'b0, cur};
        else               diff = {1'b0, cur} - {1'b0, target};
        if (stp == 12'd0 || diff <= {1'b0, stp}) nxt = target;
        else if (target > cur)                    nxt = cur + stp;
        else                                      nxt = cur - stp;
        return nxt;
    endfunction

    always_comb begin
        boundary   = (cnt_q == 12'hFFF);
        xfer       = tgt_valid && !pend_vld_q;
        eff_tgt    = pend_vld_q ? pend_q : tgt_q;
        cnt_d      = cnt_q + 12'd1;
        dc_d       = dc_q;
        tgt_d      = tgt_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;

        // A pending target is promoted and steered toward in the same boundary edge.
        if (boundary) begin
            if (pend_vld_q) begin
                tgt_d      = pend_q;
                pend_vld_d = 1'b0;
            end
            if (state_q == RAMP) dc_d = ramp_next(dc_q, eff_tgt, step);
        end

        // A transfer in the tick cycle only fills pend; it waits for the next boundary.
        if (xfer) begin
            pend_d     = tgt_data;
            pend_vld_d = 1'b1;
        end

        eff_tgt_d = pend_vld_d ? pend_d : tgt_d;
        state_d   = (dc_d != eff_tgt_d) ? RAMP : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 12'd0;
            dc_q       <= DC_INIT;
            tgt_q      <= DC_INIT;
            pend_q     <= 12'd0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dc_q       <= dc_d;
            tgt_q      <= tgt_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign tgt_ready   = !pend_vld_q;
    assign dc          = dc_q;
    assign period_tick = (cnt_q == 12'hFFF);
    assign busy        = (dc_q != tgt_q) || pend_vld_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: directed vectors, multi-period corner sequences
// and randomized traffic, all compared against a period-level reference model.
module tb_pwm_duty_ramp;

    logic        clk;
    logic        rst_n;
    logic [11:0] tgt_data;
    logic        tgt_valid;
    logic        tgt_ready;
    logic [11:0] step;
    logic [11:0] dc;
    logic        period_tick;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers updated by the ramp rules once per clock.
    int m_cnt, m_dc, m_tgt, m_pend;
    bit m_pvld;

    typedef struct {
        logic        send;
        logic [11:0] tgt;
        logic [11:0] stp;
        logic [11:0] exp_dc;
        logic        exp_busy;
    } vec_t;

    vec_t tbl [8];

    pwm_duty_ramp #(.DC_INIT(12'h000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tgt_data   (tgt_data),
        .tgt_valid  (tgt_valid),
        .tgt_ready  (tgt_ready),
        .step       (step),
        .dc         (dc),
        .period_tick(period_tick),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_dc   = 0;
        m_tgt  = 0;
        m_pend = 0;
        m_pvld = 0;
    endtask

    task automatic model_step();
        bit xf;
        int eff, d, s, mag;
        xf = tgt_valid && !m_pvld;
        if (m_cnt == 4095) begin
            eff = m_pvld ? m_pend : m_tgt;
            if (m_pvld) begin
                m_tgt  = m_pend;
                m_pvld = 0;
            end
            s   = int'(step);
            d   = eff - m_dc;
            mag = (d < 0) ? -d : d;
            if (s == 0 || mag <= s) m_dc = eff;
            else if (d > 0)         m_dc = m_dc + s;
            else                    m_dc = m_dc - s;
        end
        if (xf) begin
            m_pend = int'(tgt_data);
            m_pvld = 1;
        end
        m_cnt = (m_cnt + 1) % 4096;
    endtask

    // Advance one clock and compare every output against the model at the falling edge.
    task automatic cyc();
        logic [14:0] act_v;
        logic [14:0] exp_v;
        model_step();
        @(posedge clk);
        @(negedge clk);
        act_v = {dc, tgt_ready, busy, period_tick};
        exp_v = {12'(m_dc), ~m_pvld, (m_dc != m_tgt) || m_pvld, m_cnt == 4095};
        chk("model {dc,ready,busy,tick}", int'(act_v), int'(exp_v));
    endtask

    task automatic send(input logic [11:0] t);
        bit done;
        done      = 0;
        tgt_data  = t;
        tgt_valid = 1'b1;
        for (int i = 0; i < 9000 && !done; i++) begin
            if (tgt_ready) done = 1;
            cyc();
        end
        tgt_valid = 1'b0;
        chk("send_handshake", int'(done), 1);
    endtask

    task automatic to_tick();
        for (int i = 0; i < 4096 && m_cnt != 4095; i++) cyc();
        chk("at_tick", int'(period_tick), 1);
    endtask

    // Scramble step every cycle until the tick cycle; only the boundary value must matter.
    task automatic to_tick_rnd(input logic [11:0] s_final);
        for (int i = 0; i < 4096 && m_cnt != 4095; i++) begin
            step = 12'($urandom);
            cyc();
        end
        step = s_final;
        chk("at_tick", int'(period_tick), 1);
    endtask

    initial begin
        tbl[0] = '{1'b1, 12'hFF8, 12'h000, 12'hFF8, 1'b0};
        tbl[1] = '{1'b1, 12'hFFF, 12'h010, 12'hFFF, 1'b0};
        tbl[2] = '{1'b1, 12'h000, 12'hFFF, 12'h000, 1'b0};
        tbl[3] = '{1'b1, 12'h100, 12'h040, 12'h040, 1'b1};
        tbl[4] = '{1'b0, 12'h000, 12'h040, 12'h080, 1'b1};
        tbl[5] = '{1'b0, 12'h000, 12'h040, 12'h0C0, 1'b1};
        tbl[6] = '{1'b0, 12'h000, 12'h040, 12'h100, 1'b0};
        tbl[7] = '{1'b1, 12'h0F0, 12'h300, 12'h0F0, 1'b0};

        rst_n     = 1'b1;
        tgt_valid = 1'b0;
        tgt_data  = 12'h000;
        step      = 12'h000;
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_dc", int'(dc), 0);
        chk("rst_ready", int'(tgt_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tick", int'(period_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: tick exactly at the end of each 4096-cycle period, dc held.
        for (int k = 1; k <= 8201; k++) begin
            cyc();
            chk("idle_tick", int'(period_tick), int'((k % 4096) == 4095));
        end
        chk("idle_dc", int'(dc), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_ready", int'(tgt_ready), 1);

        // Jump (step 0) to 0x0FF: pending until the boundary, then applied in one move.
        tgt_data  = 12'h0FF;
        tgt_valid = 1'b1;
        step      = 12'h000;
        cyc();
        tgt_valid = 1'b0;
        chk("jump_ready_low", int'(tgt_ready), 0);
        chk("jump_busy", int'(busy), 1);
        chk("jump_dc_hold", int'(dc), 0);
        to_tick();
        chk("jump_dc_pre", int'(dc), 0);
        cyc();
        chk("jump_dc", int'(dc), 'h0FF);
        chk("jump_busy_done", int'(busy), 0);
        chk("jump_ready", int'(tgt_ready), 1);

        for (int r = 0; r < 8; r++) begin
            step = tbl[r].stp;
            if (tbl[r].send) send(tbl[r].tgt);
            to_tick_rnd(tbl[r].stp);
            cyc();
            chk($sformatf("vec%0d_dc", r), int'(dc), int'(tbl[r].exp_dc));
            chk($sformatf("vec%0d_busy", r), int'(busy), int'(tbl[r].exp_busy));
        end

        // Mid-ramp retarget applies at the very next boundary.
        step = 12'h100;
        send(12'h800);
        to_tick_rnd(12'h100);
        cyc();
        chk("retgt_dc1", int'(dc), 'h1F0);
        chk("retgt_busy1", int'(busy), 1);
        send(12'h100);
        to_tick_rnd(12'h100);
        cyc();
        chk("retgt_dc2", int'(dc), 'h100);
        chk("retgt_busy2", int'(busy), 0);

        // Transfer during the tick cycle waits a full period; a second offer is held off.
        to_tick();
        step      = 12'h000;
        tgt_data  = 12'h180;
        tgt_valid = 1'b1;
        cyc();
        chk("tickx_dc", int'(dc), 'h100);
        chk("tickx_ready", int'(tgt_ready), 0);
        tgt_data = 12'h200;
        cyc();
        cyc();
        chk("held_ready", int'(tgt_ready), 0);
        to_tick();
        cyc();
        chk("tickx_dc_applied", int'(dc), 'h180);
        chk("held_ready_free", int'(tgt_ready), 1);
        cyc();
        chk("held_taken", int'(tgt_ready), 0);
        tgt_valid = 1'b0;
        to_tick();
        cyc();
        chk("held_dc", int'(dc), 'h200);
        chk("held_busy", int'(busy), 0);

        // Asynchronous reset in the middle of a ramp with a target pending.
        step = 12'h100;
        send(12'h800);
        to_tick();
        cyc();
        chk("pre_rst_dc", int'(dc), 'h300);
        send(12'h900);
        cyc();
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dc", int'(dc), 0);
        chk("arst_ready", int'(tgt_ready), 1);
        chk("arst_busy", int'(busy), 0);
        chk("arst_tick", int'(period_tick), 0);
        model_reset();
        @(negedge clk);
        chk("arst_dc_held", int'(dc), 0);
        tgt_valid = 1'b0;
        rst_n     = 1'b1;

        // Random traffic after release; the first tick must land on edge 4095->4096.
        for (int k = 1; k <= 4400; k++) begin
            tgt_valid = ($urandom_range(0, 5) == 0);
            tgt_data  = 12'($urandom);
            case ($urandom_range(0, 3))
                0:       step = 12'h000;
                1:       step = 12'($urandom_range(1, 16));
                2:       step = 12'($urandom_range(256, 1024));
                default: step = 12'($urandom);
            endcase
            cyc();
            if (k <= 4096) chk("post_rst_tick", int'(period_tick), int'(k == 4095));
        end
        tgt_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
